// File: rtl/output_switch_alloc.sv
// output_switch_alloc: per-output credit/round-robin/wormhole switch allocator with registered output flits
// Ports:
//   clk_i, rst_i   clock (rising edge) and synchronous active-high reset
//   valid_i        input p holds a flit
//   dir_i          one-hot requested output per input, slice p = [p*NUM_PORTS +: NUM_PORTS]
//   data_i         input flits, slice p; top two bits are the flit type
//   credit_ret_i   downstream freed one slot on output o
//   pop_o          combinational grant per input, buffer dequeues this cycle
//   valid_o        registered, output o carries a flit
//   data_o         registered output flits, zero when valid_o is low
//   err_o          sticky protocol-error flag, cleared only by reset
module output_switch_alloc #(
    parameter int NUM_PORTS       = 5,
    parameter int DATA_W          = 17,
    parameter int CREDIT_DEPTH    = 4,
    parameter int LOCAL_NO_CREDIT = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_PORTS-1:0]          valid_i,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] dir_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   data_i,
    input  logic [NUM_PORTS-1:0]          credit_ret_i,
    output logic [NUM_PORTS-1:0]          pop_o,
    output logic [NUM_PORTS-1:0]          valid_o,
    output logic [NUM_PORTS*DATA_W-1:0]   data_o,
    output logic                          err_o
);
    localparam int CW = $clog2(CREDIT_DEPTH + 1);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [CW-1:0] CMAX = CW'(CREDIT_DEPTH);

    logic [NUM_PORTS-1:0]        valid_q, valid_d;
    logic [NUM_PORTS*DATA_W-1:0] data_q, data_d;
    logic                        err_q, err_d;
    logic                        lock_q [NUM_PORTS];
    logic                        lock_d [NUM_PORTS];
    logic [PW-1:0]               owner_q [NUM_PORTS];
    logic [PW-1:0]               owner_d [NUM_PORTS];
    logic [PW-1:0]               rr_ptr_q [NUM_PORTS];
    logic [PW-1:0]               rr_ptr_d [NUM_PORTS];
    logic [CW-1:0]               cnt_q [NUM_PORTS];
    logic [CW-1:0]               cnt_d [NUM_PORTS];
    logic [1:0]                  ftype [NUM_PORTS];
    logic [NUM_PORTS-1:0]        req [NUM_PORTS];

    always_comb begin
        logic [NUM_PORTS-1:0] dv;
        logic                 oh;
        logic                 avail;
        logic                 found;
        logic                 cand;
        int                   g;
        int                   idx;
        dv      = '0;
        oh      = 1'b0;
        avail   = 1'b0;
        found   = 1'b0;
        cand    = 1'b0;
        g       = 0;
        idx     = 0;
        pop_o   = '0;
        valid_d = '0;
        data_d  = '0;
        err_d   = err_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            dv       = dir_i[p*NUM_PORTS +: NUM_PORTS];
            oh       = (dv != '0) && ((dv & (dv - NUM_PORTS'(1))) == '0);
            ftype[p] = data_i[p*DATA_W + DATA_W - 2 +: 2];
            // U-turn bit is masked out of the request but still flagged
            req[p]   = (valid_i[p] && oh) ? (dv & ~(NUM_PORTS'(1) << p)) : '0;
            if (valid_i[p] && (!oh || dv[p]))
                err_d = 1'b1;
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            lock_d[o]   = lock_q[o];
            owner_d[o]  = owner_q[o];
            rr_ptr_d[o] = rr_ptr_q[o];
            cnt_d[o]    = cnt_q[o];
            avail = (cnt_q[o] != '0) || (o == 0 && LOCAL_NO_CREDIT != 0);
            found = 1'b0;
            g     = 0;
            for (int p = 0; p < NUM_PORTS; p++)
                if (req[p][o] && !lock_q[o] && !ftype[p][1])
                    err_d = 1'b1;
            // Round-robin search starting at the pointer; a locked output only admits its owner
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = int'(rr_ptr_q[o]) + k;
                if (idx >= NUM_PORTS)
                    idx = idx - NUM_PORTS;
                cand = lock_q[o] ? (idx == int'(owner_q[o])) && req[idx][o]
                                 : req[idx][o] && ftype[idx][1];
                if (!found && cand && avail && !rst_i) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
            if (found) begin
                pop_o[g]                    = 1'b1;
                valid_d[o]                  = 1'b1;
                data_d[o*DATA_W +: DATA_W]  = data_i[g*DATA_W +: DATA_W];
                rr_ptr_d[o]                 = PW'((g + 1) % NUM_PORTS);
                if (lock_q[o] && ftype[g][1])
                    err_d = 1'b1;
                if (ftype[g] == 2'b10) begin
                    lock_d[o]  = 1'b1;
                    owner_d[o] = PW'(g);
                end else if (ftype[g][0]) begin
                    lock_d[o] = 1'b0;
                end
            end
            // Grant and return together cancel; a return into a full counter saturates
            if (o == 0 && LOCAL_NO_CREDIT != 0)
                cnt_d[o] = CMAX;
            else if (found && !credit_ret_i[o])
                cnt_d[o] = cnt_q[o] - CW'(1);
            else if (!found && credit_ret_i[o]) begin
                if (cnt_q[o] == CMAX)
                    err_d = 1'b1;
                else
                    cnt_d[o] = cnt_q[o] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                lock_q[o]   <= 1'b0;
                owner_q[o]  <= '0;
                rr_ptr_q[o] <= '0;
                cnt_q[o]    <= CMAX;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
            for (int o = 0; o < NUM_PORTS; o++) begin
                lock_q[o]   <= lock_d[o];
                owner_q[o]  <= owner_d[o];
                rr_ptr_q[o] <= rr_ptr_d[o];
                cnt_q[o]    <= cnt_d[o];
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign err_o   = err_q;
endmodule

// File: tb/tb_output_switch_alloc.sv
// tb_output_switch_alloc: vector, directed and randomized checks of output_switch_alloc
module tb_output_switch_alloc;
    localparam int N  = 5;
    localparam int W  = 17;
    localparam int CD = 4;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [N-1:0]   valid_i;
    logic [N*N-1:0] dir_i;
    logic [N*W-1:0] data_i;
    logic [N-1:0]   credit_ret_i;
    logic [N-1:0]   pop_o;
    logic [N-1:0]   valid_o;
    logic [N*W-1:0] data_o;
    logic           err_o;

    output_switch_alloc #(.NUM_PORTS(N), .DATA_W(W), .CREDIT_DEPTH(CD), .LOCAL_NO_CREDIT(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .dir_i(dir_i), .data_i(data_i),
        .credit_ret_i(credit_ret_i), .pop_o(pop_o), .valid_o(valid_o), .data_o(data_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int passed = 0;
    int total  = 0;

    logic [N-1:0]   pop_s, vo_s;
    logic [N*W-1:0] do_s;
    logic           err_s;

    int             m_cred [N];
    bit             m_lock [N];
    int             m_own  [N];
    int             m_rr   [N];
    bit             m_err;
    logic [N-1:0]   exp_pop, exp_vo;
    logic [N*W-1:0] exp_do;
    logic           exp_err;

    typedef struct {
        logic [N-1:0]   v;
        logic [N*N-1:0] d;
        logic [N*W-1:0] dat;
        logic [N-1:0]   cr;
        logic [N-1:0]   ep;
        logic [N-1:0]   ev;
        int             oc;
        logic [W-1:0]   ed;
        logic           ee;
    } vec_t;
    vec_t tv [10];

    function automatic logic [N*N-1:0] dr(int p, int o);
        logic [N*N-1:0] r;
        r = '0;
        r[p*N+o] = 1'b1;
        return r;
    endfunction

    function automatic logic [N*W-1:0] dt(int p, logic [W-1:0] f);
        logic [N*W-1:0] r;
        r = '0;
        r[p*W +: W] = f;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference: each output picks the eligible requester at the smallest rotational distance from its pointer
    task automatic model_eval();
        exp_pop = '0;
        exp_vo  = '0;
        exp_do  = '0;
        if (rst_i) begin
            for (int o = 0; o < N; o++) begin
                m_cred[o] = CD; m_lock[o] = 0; m_own[o] = 0; m_rr[o] = 0;
            end
            m_err   = 0;
            exp_err = 0;
            return;
        end
        for (int p = 0; p < N; p++) begin
            logic [N-1:0] dv = dir_i[p*N +: N];
            if (valid_i[p] && ($countones(dv) != 1 || dv[p])) m_err = 1;
        end
        for (int o = 0; o < N; o++) begin
            int  best  = -1;
            int  bd    = N;
            bit  avail = (m_cred[o] > 0) || (o == 0);
            for (int p = 0; p < N; p++) begin
                logic [N-1:0] dv = dir_i[p*N +: N];
                logic [1:0]   ty = data_i[p*W + W - 2 +: 2];
                bit rq = valid_i[p] && $countones(dv) == 1 && dv[o] && o != p;
                bit el;
                if (!rq) continue;
                if (!m_lock[o] && !ty[1]) m_err = 1;
                el = m_lock[o] ? (p == m_own[o]) : ty[1];
                if (el && avail && ((p - m_rr[o] + N) % N) < bd) begin
                    bd   = (p - m_rr[o] + N) % N;
                    best = p;
                end
            end
            if (best >= 0) begin
                logic [1:0] tb_ty = data_i[best*W + W - 2 +: 2];
                exp_pop[best]     = 1'b1;
                exp_vo[o]         = 1'b1;
                exp_do[o*W +: W]  = data_i[best*W +: W];
                m_rr[o]           = (best + 1) % N;
                if (m_lock[o] && tb_ty[1]) m_err = 1;
                if (tb_ty == 2'b10) begin m_lock[o] = 1; m_own[o] = best; end
                else if (tb_ty[0]) m_lock[o] = 0;
            end
            if (o != 0) begin
                m_cred[o] = m_cred[o] + int'(credit_ret_i[o]) - ((best >= 0) ? 1 : 0);
                if (m_cred[o] > CD) begin m_cred[o] = CD; m_err = 1; end
            end
        end
        exp_err = m_err;
    endtask

    task automatic step(input logic r, input logic [N-1:0] v, input logic [N*N-1:0] d,
                        input logic [N*W-1:0] dat, input logic [N-1:0] cr);
        rst_i = r; valid_i = v; dir_i = d; data_i = dat; credit_ret_i = cr;
        model_eval();
        #1 pop_s = pop_o;
        @(posedge clk_i);
        #1;
        vo_s = valid_o; do_s = data_o; err_s = err_o;
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        step(1'b1, '0, '0, '0, '0);
    endtask

    task automatic drive_chk(input string nm, input logic [N-1:0] v, input logic [N*N-1:0] d,
                             input logic [N*W-1:0] dat, input logic [N-1:0] cr, input logic [N-1:0] ep,
                             input logic [N-1:0] ev, input int oc, input logic [W-1:0] ed, input logic ee);
        step(1'b0, v, d, dat, cr);
        chk({nm, "_pop"}, pop_s, ep);
        chk({nm, "_vo"}, vo_s, ev);
        chk({nm, "_data"}, do_s[oc*W +: W], ed);
        chk({nm, "_err"}, err_s, ee);
    endtask

    initial begin
        logic [N*N-1:0] rr_d;
        logic [N*W-1:0] rr_dat;
        rr_d   = dr(0, 3) | dr(1, 3) | dr(2, 3);
        rr_dat = dt(0, 17'h18001) | dt(1, 17'h18002) | dt(2, 17'h18003);
        tv[0] = '{5'b00010, dr(1, 4), dt(1, 17'h18AAA), 5'b00000, 5'b00010, 5'b10000, 4, 17'h18AAA, 1'b0};
        tv[1] = '{5'b00111, rr_d, rr_dat, 5'b00000, 5'b00001, 5'b01000, 3, 17'h18001, 1'b0};
        tv[2] = '{5'b00111, rr_d, rr_dat, 5'b00000, 5'b00010, 5'b01000, 3, 17'h18002, 1'b0};
        tv[3] = '{5'b00111, rr_d, rr_dat, 5'b00000, 5'b00100, 5'b01000, 3, 17'h18003, 1'b0};
        tv[4] = '{5'b00111, rr_d, rr_dat, 5'b00000, 5'b00001, 5'b01000, 3, 17'h18001, 1'b0};
        tv[5] = '{5'b00111, rr_d, rr_dat, 5'b00000, 5'b00000, 5'b00000, 3, 17'h00000, 1'b0};
        tv[6] = '{5'b00111, rr_d, rr_dat, 5'b01000, 5'b00000, 5'b00000, 3, 17'h00000, 1'b0};
        tv[7] = '{5'b00111, rr_d, rr_dat, 5'b01000, 5'b00010, 5'b01000, 3, 17'h18002, 1'b0};
        tv[8] = '{5'b00111, rr_d, rr_dat, 5'b01000, 5'b00100, 5'b01000, 3, 17'h18003, 1'b0};
        tv[9] = '{5'b00111, rr_d, rr_dat, 5'b01000, 5'b00001, 5'b01000, 3, 17'h18001, 1'b0};

        rst_i = 1'b1; valid_i = '0; dir_i = '0; data_i = '0; credit_ret_i = '0;
        @(negedge clk_i);
        do_reset();
        chk("reset_vo", vo_s, 5'b0);
        chk("reset_data", do_s, '0);
        chk("reset_err", err_s, 1'b0);
        chk("reset_pop", pop_s, 5'b0);

        for (int i = 0; i < 10; i++)
            drive_chk($sformatf("vec%0d", i), tv[i].v, tv[i].d, tv[i].dat, tv[i].cr,
                      tv[i].ep, tv[i].ev, tv[i].oc, tv[i].ed, tv[i].ee);

        do_reset();
        drive_chk("lock_h", 5'b11000, dr(3, 2) | dr(4, 2), dt(3, 17'h10031) | dt(4, 17'h10041), 5'b00100, 5'b01000, 5'b00100, 2, 17'h10031, 1'b0);
        drive_chk("lock_b1", 5'b11000, dr(3, 2) | dr(4, 2), dt(3, 17'h00032) | dt(4, 17'h10041), 5'b00100, 5'b01000, 5'b00100, 2, 17'h00032, 1'b0);
        drive_chk("lock_b2", 5'b11000, dr(3, 2) | dr(4, 2), dt(3, 17'h00033) | dt(4, 17'h10041), 5'b00100, 5'b01000, 5'b00100, 2, 17'h00033, 1'b0);
        drive_chk("lock_t", 5'b11000, dr(3, 2) | dr(4, 2), dt(3, 17'h08034) | dt(4, 17'h10041), 5'b00100, 5'b01000, 5'b00100, 2, 17'h08034, 1'b0);
        drive_chk("lock_next", 5'b10000, dr(4, 2), dt(4, 17'h10041), 5'b00100, 5'b10000, 5'b00100, 2, 17'h10041, 1'b0);

        do_reset();
        drive_chk("cred_g1", 5'b00010, dr(1, 4), dt(1, 17'h18011), 5'b0, 5'b00010, 5'b10000, 4, 17'h18011, 1'b0);
        drive_chk("cred_g2", 5'b00010, dr(1, 4), dt(1, 17'h18012), 5'b0, 5'b00010, 5'b10000, 4, 17'h18012, 1'b0);
        drive_chk("cred_gr", 5'b00010, dr(1, 4), dt(1, 17'h18013), 5'b10000, 5'b00010, 5'b10000, 4, 17'h18013, 1'b0);
        drive_chk("cred_g3", 5'b00010, dr(1, 4), dt(1, 17'h18014), 5'b0, 5'b00010, 5'b10000, 4, 17'h18014, 1'b0);
        drive_chk("cred_g4", 5'b00010, dr(1, 4), dt(1, 17'h18015), 5'b0, 5'b00010, 5'b10000, 4, 17'h18015, 1'b0);
        drive_chk("cred_stall", 5'b00010, dr(1, 4), dt(1, 17'h18016), 5'b0, 5'b00000, 5'b00000, 4, 17'h00000, 1'b0);
        drive_chk("cred_sat", 5'b0, '0, '0, 5'b01000, 5'b0, 5'b0, 3, 17'h0, 1'b1);
        drive_chk("cred_sticky", 5'b0, '0, '0, 5'b0, 5'b0, 5'b0, 3, 17'h0, 1'b1);

        do_reset();
        for (int i = 0; i < 10; i++)
            drive_chk($sformatf("local%0d", i), 5'b00010, dr(1, 0), dt(1, W'(17'h18100 + i)), 5'b0,
                      5'b00010, 5'b00001, 0, W'(17'h18100 + i), 1'b0);
        drive_chk("local_ret", 5'b0, '0, '0, 5'b00001, 5'b0, 5'b0, 0, 17'h0, 1'b0);

        do_reset();
        drive_chk("err_body", 5'b00010, dr(1, 4), dt(1, 17'h00055), 5'b0, 5'b0, 5'b0, 4, 17'h0, 1'b1);
        do_reset();
        drive_chk("err_uturn", 5'b00100, dr(2, 2), dt(2, 17'h18022), 5'b0, 5'b0, 5'b0, 2, 17'h0, 1'b1);
        do_reset();
        drive_chk("err_multi", 5'b00010, dr(1, 2) | dr(1, 3), dt(1, 17'h18033), 5'b0, 5'b0, 5'b0, 3, 17'h0, 1'b1);
        drive_chk("err_hold", 5'b0, '0, '0, 5'b0, 5'b0, 5'b0, 3, 17'h0, 1'b1);

        do_reset();
        drive_chk("mid_head", 5'b00010, dr(1, 4), dt(1, 17'h10011), 5'b0, 5'b00010, 5'b10000, 4, 17'h10011, 1'b0);
        step(1'b1, 5'b00010, dr(1, 4), dt(1, 17'h00012), 5'b0);
        chk("mid_rst_pop", pop_s, 5'b0);
        chk("mid_rst_vo", vo_s, 5'b0);
        chk("mid_rst_data", do_s, '0);
        drive_chk("mid_after", 5'b00110, dr(1, 4) | dr(2, 4), dt(1, 17'h00013) | dt(2, 17'h10022), 5'b0,
                  5'b00100, 5'b10000, 4, 17'h10022, 1'b1);

        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0]   v, cr;
            logic [N*N-1:0] d;
            logic [N*W-1:0] dat;
            logic           r;
            r = ($urandom_range(0, 63) == 0);
            v = N'($urandom);
            cr = '0;
            for (int p = 0; p < N; p++) begin
                logic [N-1:0] dv;
                logic [1:0]   ty;
                dv = ($urandom_range(0, 11) == 0) ? N'($urandom) : N'(1) << $urandom_range(0, N - 1);
                ty = 2'($urandom);
                d[p*N +: N]   = dv;
                dat[p*W +: W] = {ty, 15'($urandom)};
                cr[p]         = ($urandom_range(0, 2) == 0);
            end
            step(r, v, d, dat, cr);
            chk("rnd_pop", pop_s, exp_pop);
            chk("rnd_vo", vo_s, exp_vo);
            chk("rnd_data", do_s, exp_do);
            chk("rnd_err", err_s, exp_err);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
